// File: rtl/shift_normalizer_pkg.sv
// shift_normalizer_pkg: shared shift/normalize codes, state encoding and sizes
package shift_normalizer_pkg;
  localparam int DATA_W = 32;
  localparam int SHAMT_W = 5;
  typedef enum logic [1:0] {SHOP_SRL = 2'b00, SHOP_SRA = 2'b01, SHOP_SLL = 2'b10} shop_e;
  typedef enum logic {NORM_LOG = 1'b0, NORM_ARI = 1'b1} norm_mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_CALC = 1'b1} state_e;
endpackage

// File: rtl/shift_normalizer_norm_step.sv
// shift_normalizer_norm_step: one binary-search step, shift left by s if the top bits are redundant
module shift_normalizer_norm_step
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int AMT_W = SHAMT_W
) (
  input  logic [WIDTH-1:0] w,
  input  logic [AMT_W-1:0] s,
  input  logic             mode,
  output logic             take,
  output logic [WIDTH-1:0] w_next
);
  logic [WIDTH-1:0] y;
  // arithmetic mode folds the sign away so both modes reduce to a leading-zero test
  assign y = (mode == NORM_ARI) ? ((w ^ {WIDTH{w[WIDTH-1]}}) << 1) : w;
  assign take = (y >> (WIDTH - int'(s))) == '0;
  assign w_next = take ? (w << s) : w;
endmodule

// File: rtl/shift_normalizer.sv
// shift_normalizer: fixed 5-step normalizer returning left-shift amount and normalized word
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int AMT_W = SHAMT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [AMT_W-1:0] amount,
  output logic             zero
);
  state_e state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [WIDTH-1:0] w_q, w_d, w_next, result_q, result_d;
  logic [AMT_W-1:0] acc_q, acc_d, amount_q, amount_d, s;
  logic mode_q, mode_d, zf_q, zf_d, done_q, done_d, zero_q, zero_d;
  logic take, go, calc, fin;
  assign s = AMT_W'((WIDTH / 2) >> k_q);
  shift_normalizer_norm_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
    .w(w_q), .s(s), .mode(mode_q), .take(take), .w_next(w_next)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb begin
    go = state_q == ST_IDLE && start;
    calc = state_q == ST_CALC;
    fin = calc && k_q == 3'(AMT_W - 1);
    state_d = go ? ST_CALC : fin ? ST_IDLE : state_q;
  end
  always_comb begin
    w_d = go ? in : calc ? w_next : w_q;
    mode_d = go ? mode : mode_q;
    zf_d = go ? (in == '0 || (mode == NORM_ARI && in == '1)) : zf_q;
    acc_d = go ? '0 : (calc && take) ? acc_q + s : acc_q;
    k_d = go ? '0 : calc ? k_q + 3'd1 : k_q;
    done_d = fin;
    result_d = fin ? w_next : result_q;
    amount_d = fin ? acc_d : amount_q;
    zero_d = fin ? zf_q : zero_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      k_q <= '0;
      w_q <= '0;
      mode_q <= 1'b0;
      zf_q <= 1'b0;
      acc_q <= '0;
      done_q <= 1'b0;
      result_q <= '0;
      amount_q <= '0;
      zero_q <= 1'b0;
    end else begin
      k_q <= k_d;
      w_q <= w_d;
      mode_q <= mode_d;
      zf_q <= zf_d;
      acc_q <= acc_d;
      done_q <= done_d;
      result_q <= result_d;
      amount_q <= amount_d;
      zero_q <= zero_d;
    end
  always_comb begin
    busy = state_q == ST_CALC;
    done = done_q;
    result = result_q;
    amount = amount_q;
    zero = zero_q;
  end
endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: vector table, handshake/reset sequences, random and sweep checks vs a reference model
module tb_shift_normalizer;
  logic clock = 0, reset_n = 0, start = 0, mode = 0;
  logic [31:0] in_v = 0;
  logic busy, done, zero;
  logic [31:0] result;
  logic [4:0] amount;
  int n_cmp = 0, n_fail = 0;

  shift_normalizer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .in(in_v),
    .busy(busy), .done(done), .result(result), .amount(amount), .zero(zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic m;
    logic [31:0] v;
    logic [4:0] amt;
    logic [31:0] res;
    logic z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] shifter(input logic [31:0] a, input logic [1:0] op, input logic [4:0] amt);
    case (op)
      2'b00: return a >> amt;
      2'b01: return $unsigned($signed(a) >>> amt);
      default: return a << amt;
    endcase
  endfunction

  // count of leading zeros (logical) or redundant sign bits (arithmetic), capped at 31
  function automatic logic [4:0] ref_amt(input logic m, input logic [31:0] v);
    int n = 0;
    if (!m) begin
      for (int i = 31; i >= 0 && v[i] == 1'b0; i--) n++;
      if (n > 31) n = 31;
    end else
      for (int i = 30; i >= 0 && v[i] == v[31]; i--) n++;
    return 5'(n);
  endfunction

  function automatic logic ref_zero(input logic m, input logic [31:0] v);
    return v == 32'h0 || (m && v == 32'hFFFF_FFFF);
  endfunction

  task automatic do_op(input logic m, input logic [31:0] v,
                       output logic [31:0] r, output logic [4:0] a, output logic z);
    int lat, nb;
    bit got;
    @(negedge clock);
    start = 1; mode = m; in_v = v;
    @(posedge clock);
    #1 start = 0; in_v = $urandom; mode = 1'($urandom);
    lat = 0; nb = 0; got = 0;
    while (!got && lat < 12) begin
      @(negedge clock);
      lat++;
      if (done) got = 1;
      else if (busy) nb++;
    end
    chk("latency", lat, 6);
    chk("busy_cycles", nb, 5);
    r = result; a = amount; z = zero;
    @(negedge clock);
    chk("done_one_cycle", {31'b0, done}, 0);
  endtask

  task automatic check_model(input string tag, input logic m, input logic [31:0] v);
    logic [31:0] r;
    logic [4:0] a;
    logic z;
    do_op(m, v, r, a, z);
    chk({tag, "_amount"}, {27'b0, a}, {27'b0, ref_amt(m, v)});
    chk({tag, "_zero"}, {31'b0, z}, {31'b0, ref_zero(m, v)});
    chk({tag, "_sll"}, r, shifter(v, 2'b10, a));
    if (!m && v != 0) chk({tag, "_srl_back"}, shifter(r, 2'b00, a), v);
  endtask

  localparam logic [31:0] SWEEP_FROM = 32'h0000_0F00;
  localparam logic [31:0] SWEEP_STEP = 32'h0137_1111;
  localparam int SWEEP_QUANT = 24;

  initial begin
    vec_t tbl[10];
    logic [31:0] r, v;
    logic [4:0] a;
    logic z;
    int pulses, first_at, second_at;
    bit seen;
    tbl = '{
      '{1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0},
      '{1'b0, 32'h00F0_0000, 5'd8,  32'hF000_0000, 1'b0},
      '{1'b0, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0},
      '{1'b1, 32'hFFFF_8000, 5'd16, 32'h8000_0000, 1'b0},
      '{1'b1, 32'h0000_0001, 5'd30, 32'h4000_0000, 1'b0},
      '{1'b1, 32'h0000_0000, 5'd31, 32'h0000_0000, 1'b1},
      '{1'b1, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1},
      '{1'b0, 32'h0000_0000, 5'd31, 32'h0000_0000, 1'b1},
      '{1'b1, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0},
      '{1'b0, 32'h0000_0100, 5'd23, 32'h8000_0000, 1'b0}
    };
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_result", result, 0);
    chk("rst_amount", {27'b0, amount}, 0);
    chk("rst_zero", {31'b0, zero}, 0);
    @(negedge clock);
    reset_n = 1;

    foreach (tbl[i]) begin
      do_op(tbl[i].m, tbl[i].v, r, a, z);
      chk($sformatf("vec%0d_amount", i), {27'b0, a}, {27'b0, tbl[i].amt});
      chk($sformatf("vec%0d_result", i), r, tbl[i].res);
      chk($sformatf("vec%0d_zero", i), {31'b0, z}, {31'b0, tbl[i].z});
    end

    // start held high: back-to-back ops every 6 cycles
    @(negedge clock);
    start = 1; mode = 0; in_v = 32'h0000_0100;
    pulses = 0; first_at = 0; second_at = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clock);
      if (done) begin
        pulses++;
        if (pulses == 1) first_at = c;
        if (pulses == 2) second_at = c;
        chk("held_amount", {27'b0, amount}, 23);
      end
    end
    start = 0;
    chk("held_pulses", pulses, 2);
    chk("held_period", second_at - first_at, 6);
    repeat (8) @(negedge clock);

    // operand and mode changes plus a start while busy are ignored
    start = 1; mode = 0; in_v = 32'h00F0_0000;
    @(negedge clock);
    in_v = 32'h0000_0001; mode = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      start = (c < 3);
      @(negedge clock);
      if (done) seen = 1;
    end
    start = 0;
    chk("busy_ignore_done", {31'b0, seen}, 1);
    chk("busy_ignore_amount", {27'b0, amount}, 8);
    chk("busy_ignore_result", result, 32'hF000_0000);
    repeat (2) @(negedge clock);

    // asynchronous reset after the third step
    start = 1; mode = 0; in_v = 32'h0000_0003;
    @(posedge clock);
    #1 start = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_done", {31'b0, done}, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_amount", {27'b0, amount}, 0);
    chk("mid_rst_zero", {31'b0, zero}, 0);
    @(negedge clock);
    reset_n = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (done || busy) seen = 1;
    end
    chk("no_done_after_rst", {31'b0, seen}, 0);

    for (int i = 0; i < 150; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = ~v;
      if ($urandom_range(0, 15) == 0) v = 0;
      check_model("rand", 1'($urandom), v);
    end

    for (int m = 0; m < 2; m++) begin
      v = SWEEP_FROM;
      for (int i = 0; i < SWEEP_QUANT; i++) begin
        check_model("sweep", 1'(m), v);
        v = v + SWEEP_STEP;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
